nested_loop_counter: RTL and testbench

//  Parametrised multi-level loop counter, the successor to the single-column weight counter.

---
 rtl/nested_loop_counter.sv | 110 +++++++++++
 tb/tb_nested_loop_counter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/nested_loop_counter.sv
// Multi-level nested loop counter with start/busy/done handshake.
// Level 0 is innermost; each level carries into the next when it wraps.
module nested_loop_counter #(
   parameter int NUM_LEVELS = 2,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [NUM_LEVELS*CNT_WIDTH-1:0]  bounds,
   input  logic                             advance,
   input  logic                             abort,
   output logic [NUM_LEVELS*CNT_WIDTH-1:0]  count,
   output logic [NUM_LEVELS-1:0]            wrap,
   output logic                             busy,
   output logic                             done,
   output logic                             cfg_err
);

   localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, RUN} state_t;

   state_t                          state_reg;
   logic [NUM_LEVELS*CNT_WIDTH-1:0] count_reg;
   logic [NUM_LEVELS*CNT_WIDTH-1:0] bound_reg;
   logic [NUM_LEVELS-1:0]           wrap_reg;
   logic                            busy_reg;
   logic                            done_reg;
   logic                            cfg_err_reg;

   logic [NUM_LEVELS:0]             carry;
   logic [NUM_LEVELS-1:0]           level_wrap;
   logic [NUM_LEVELS-1:0]           bound_nonzero;
   logic [NUM_LEVELS*CNT_WIDTH-1:0] count_next;
   logic                            bounds_ok;

   // carry[0] is the advance request itself; the FSM only consumes count_next on advance
   assign carry[0] = 1'b1;

   generate
      for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_level
         logic [CNT_WIDTH-1:0] cur;
         logic [CNT_WIDTH-1:0] bnd;
         assign cur                = count_reg[gi*CNT_WIDTH +: CNT_WIDTH];
         assign bnd                = bound_reg[gi*CNT_WIDTH +: CNT_WIDTH];
         assign level_wrap[gi]     = carry[gi] && (cur == (bnd - ONE));
         assign carry[gi+1]        = level_wrap[gi];
         assign bound_nonzero[gi]  = (bounds[gi*CNT_WIDTH +: CNT_WIDTH] != '0);
         assign count_next[gi*CNT_WIDTH +: CNT_WIDTH] =
            level_wrap[gi] ? '0 : (carry[gi] ? cur + ONE : cur);
      end
   endgenerate

   assign bounds_ok = &bound_nonzero;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         count_reg   <= '0;
         bound_reg   <= '0;
         wrap_reg    <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         cfg_err_reg <= 1'b0;
      end else begin
         wrap_reg    <= '0;
         done_reg    <= 1'b0;
         cfg_err_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (bounds_ok) begin
                     bound_reg <= bounds;
                     count_reg <= '0;
                     busy_reg  <= 1'b1;
                     state_reg <= RUN;
                  end else begin
                     cfg_err_reg <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  count_reg <= '0;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else if (advance) begin
                  count_reg <= count_next;
                  wrap_reg  <= level_wrap;
                  // outermost carry-out means every level wrapped: run complete
                  if (carry[NUM_LEVELS]) begin
                     done_reg  <= 1'b1;
                     busy_reg  <= 1'b0;
                     state_reg <= IDLE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign count   = count_reg;
   assign wrap    = wrap_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;
   assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_nested_loop_counter.sv
// Bench for nested_loop_counter: model tracks a linear iteration number and derives
// per-level indices and wraps by mixed-radix arithmetic; directed scenarios plus random traffic.
module tb_nested_loop_counter;
   localparam int L = 2;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           reset, start, advance, abort;
   logic [L*W-1:0] bounds;
   logic [L*W-1:0] count;
   logic [L-1:0]   wrap;
   logic           busy, done, cfg_err;

   always #5 clk = ~clk;

   nested_loop_counter #(.NUM_LEVELS(L), .CNT_WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .bounds(bounds),
      .advance(advance), .abort(abort), .count(count), .wrap(wrap),
      .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   int         m_b[L];
   int         m_iter;
   bit         m_busy;
   logic [L-1:0] e_wrap;
   bit         e_done, e_cfg;

   function automatic logic [L*W-1:0] exp_count();
      logic [L*W-1:0] r = '0;
      int rem = m_iter;
      if (!m_busy) return '0;
      for (int i = 0; i < L; i++) begin
         r[i*W +: W] = W'(rem % m_b[i]);
         rem = rem / m_b[i];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
      end
   endtask

   task automatic model_update(input logic r, input logic s, input logic [L*W-1:0] b,
                               input logic adv, input logic ab);
      int p, total;
      bit zero;
      e_wrap = '0; e_done = 0; e_cfg = 0;
      if (r) begin
         m_busy = 0; m_iter = 0;
         for (int i = 0; i < L; i++) m_b[i] = 0;
      end else if (!m_busy) begin
         if (s) begin
            zero = 0;
            for (int i = 0; i < L; i++) if (b[i*W +: W] == 0) zero = 1;
            if (zero) e_cfg = 1;
            else begin
               for (int i = 0; i < L; i++) m_b[i] = int'(b[i*W +: W]);
               m_iter = 0; m_busy = 1;
            end
         end
      end else if (ab) begin
         m_busy = 0; m_iter = 0;
      end else if (adv) begin
         p = 1;
         for (int i = 0; i < L; i++) begin
            p = p * m_b[i];
            if ((m_iter + 1) % p == 0) e_wrap[i] = 1'b1;
         end
         total = p;
         m_iter++;
         if (m_iter == total) begin
            e_done = 1; m_busy = 0; m_iter = 0;
         end
      end
   endtask

   // One clock: drive at negedge, model steps at posedge, outputs compared at next negedge.
   task automatic cycle(input logic r, input logic s, input logic [L*W-1:0] b,
                        input logic adv, input logic ab);
      reset = r; start = s; bounds = b; advance = adv; abort = ab;
      @(posedge clk);
      model_update(r, s, b, adv, ab);
      @(negedge clk);
      cyc++;
      check("count",   32'(count),   32'(exp_count()));
      check("wrap",    32'(wrap),    32'(e_wrap));
      check("busy",    32'(busy),    32'(m_busy));
      check("done",    32'(done),    32'(e_done));
      check("cfg_err", 32'(cfg_err), 32'(e_cfg));
   endtask

   logic [7:0] s1c [6] = '{8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h00};
   logic [1:0] s1w [6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b11};

   initial begin
      reset = 1; start = 0; bounds = '0; advance = 0; abort = 0;
      m_busy = 0; m_iter = 0; e_wrap = '0; e_done = 0; e_cfg = 0;
      for (int i = 0; i < L; i++) m_b[i] = 0;
      @(negedge clk);
      cycle(1, 0, 8'h00, 0, 0);
      cycle(1, 1, 8'h32, 1, 0);
      check("reset_state", 32'({count, wrap, busy, done, cfg_err}), 32'd0);

      // Scenario 1: bounds L1=3, L0=2, six advances
      cycle(0, 1, 8'h32, 0, 0);
      check("s1_busy_on", 32'(busy), 32'd1);
      for (int k = 0; k < 6; k++) begin
         cycle(0, 0, 8'h32, 1, 0);
         check("s1_count", 32'(count), 32'(s1c[k]));
         check("s1_wrap",  32'(wrap),  32'(s1w[k]));
         check("s1_done",  32'(done),  (k == 5) ? 32'd1 : 32'd0);
      end
      check("s1_busy_off", 32'(busy), 32'd0);

      // Scenario 2: zero bound rejected
      cycle(0, 1, 8'h02, 0, 0);
      check("s2_cfg_err", 32'(cfg_err), 32'd1);
      cycle(0, 0, 8'h02, 1, 0);
      check("s2_idle", 32'({count, busy, cfg_err}), 32'd0);

      // Scenario 3: abort beats advance
      cycle(0, 1, 8'h32, 0, 0);
      repeat (3) cycle(0, 0, 8'h32, 1, 0);
      check("s3_count11", 32'(count), 32'h11);
      cycle(0, 0, 8'h32, 1, 1);
      check("s3_abort", 32'({count, wrap, busy, done}), 32'd0);

      // Scenario 4: reset mid-run at count 21
      cycle(0, 1, 8'h32, 0, 0);
      repeat (5) cycle(0, 0, 8'h32, 1, 0);
      check("s4_count21", 32'(count), 32'h21);
      cycle(1, 0, 8'h32, 1, 0);
      check("s4_reset", 32'({count, wrap, busy, done, cfg_err}), 32'd0);

      // Scenario 5: L1=15, L0=1
      cycle(0, 1, 8'hF1, 0, 0);
      for (int k = 1; k <= 15; k++) begin
         cycle(0, 0, 8'hF1, 1, 0);
         check("s5_wrap0", 32'(wrap[0]), 32'd1);
         if (k == 14) check("s5_count_e0", 32'(count), 32'hE0);
         check("s5_done", 32'(done), (k == 15) ? 32'd1 : 32'd0);
      end

      // Scenario 6: start/bounds ignored during run, then 1/1 run
      cycle(0, 1, 8'h32, 0, 0);
      for (int k = 0; k < 6; k++) cycle(0, (k == 2), (k == 2) ? 8'h11 : 8'h32, 1, 0);
      check("s6_done_orig", 32'(done), 32'd1);
      cycle(0, 1, 8'h11, 0, 0);
      cycle(0, 0, 8'h11, 1, 0);
      check("s6_done_11", 32'({wrap, done, busy}), 32'b1110);

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         logic [L*W-1:0] b;
         for (int i = 0; i < L; i++)
            b[i*W +: W] = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 15))
                                                       : W'($urandom_range(0, 4));
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), b,
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "timeout");
   end
endmodule
